branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- EX-stage branch resolution controller. Consumes the comparator's br_en plus the branch/jump info held in ID/EX.
- Maintains a 2-bit saturating branch history table (BHT), which supplies the IF-stage prediction.
- Detects mispredicts, drives the PC redirect and the IF/ID and ID/EX flushes, and holds a pending redirect across pipeline stalls.
- Keeps saturating branch and mispredict performance counters.

Parameters:
- BHT_IDX_W, 6, log2 of BHT entries (64); index = pc[BHT_IDX_W+1:2].
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_pc  in  32  PC of the instruction in fetch.
- pred_taken  out  1  BHT prediction for if_pc: counter MSB, combinational read.
- stall  in  1  global pipeline stall; EX holds its instruction while high.
- ex_valid  in  1  EX holds a valid, unsquashed instruction.
- ex_is_branch  in  1  conditional branch in EX.
- ex_is_jump  in  1  JAL/JALR in EX.
- ex_pc  in  32  PC of the EX instruction.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_target  in  32  computed branch/jump target.
- br_en  in  1  comparator result for the EX branch.
- redirect_valid  out  1  load redirect_pc into the PC this cycle.
- redirect_pc  out  32  corrected fetch address.
- flush_if_id  out  1  squash the IF/ID register at this edge.
- flush_id_ex  out  1  squash the ID/EX register at this edge.
- br_count  out  CNT_W  resolved conditional branches.
- mispred_count  out  CNT_W  mispredicted branches plus jumps.

Behaviour:
- Reset (rst low, async):
  - FSM = IDLE.
  - Every BHT entry = 2'b01 (weakly not-taken).
  - Counters = 0; pending registers = 0.
  - redirect_valid, flush_if_id, flush_id_ex = 0; redirect_pc = 0.
- Resolve event R = ex_valid & (ex_is_branch | ex_is_jump).
- actual = ex_is_jump ? 1 : br_en.
- Mispredict M:
  - Jumps: M = 1 always.
  - Branches: M = (br_en != ex_pred_taken).
- Correct PC C = actual ? ex_target : ex_pc + 4 (mod 2^32).
- FSM states: IDLE, PEND.
- IDLE, R & M & !stall (same-cycle, Mealy):
  - redirect_valid = flush_if_id = flush_id_ex = 1, redirect_pc = C.
  - Stay IDLE.
- IDLE, R & M & stall:
  - Latch C into pend_pc, pend_is_branch, pend_actual.
  - Go to PEND; outputs stay 0 this cycle.
- PEND, stall = 1:
  - Outputs 0; hold state. ex_* inputs are ignored.
- PEND, stall = 0:
  - redirect_valid/flushes = 1, redirect_pc = pend_pc.
  - Go to IDLE. ex_* inputs are ignored this cycle.
- Correctly predicted branch: no redirect, no flush.
- All redirect/flush outputs are 0 whenever no redirect condition holds.
- BHT and counter updates happen exactly once per resolved instruction, at the edge where it leaves EX:
  - IDLE & R & !stall, or PEND & !stall.
  - Never while stall is high.
- BHT update (branches only, never jumps), at index of ex_pc (or the PC latched for PEND):
  - actual = 1: counter increments, saturating at 2'b11.
  - actual = 0: counter decrements, saturating at 2'b00.
- Counters, both saturating at all-ones (no wrap):
  - br_count +1 per branch.
  - mispred_count +1 per M (branch or jump).
- Same-cycle BHT write and IF read of the same index: pred_taken returns the pre-update value (no bypass).
- ex_valid = 0 or a non-control instruction: no state change.
- Reset asserted while in PEND: pending redirect is discarded and all outputs drop to 0 immediately (async).

Decomposition:
- Shared types package gains:
  - bht_state_t (2-bit enum: SNT = 00, WNT = 01, WT = 10, ST = 11).
  - branch_ctrl_state_t (IDLE, PEND).
  - Constant BHT_RESET_VAL = WNT.
- One sub-module, bht:
  - Counter array with async reset.
  - Combinational read port (if_pc).
  - Single write port (index, actual, enable) containing the saturating update.
- branch_ctrl holds the FSM, the redirect mux and the perf counters.

Test Plan:
- Reset, if_pc = 0x100 -> pred_taken = 0. Branch at 0x100, ex_pred_taken = 0, br_en = 1, stall = 0, ex_target = 0x80 -> same cycle redirect_valid = 1, redirect_pc = 0x80, both flushes = 1; next cycle outputs 0, pred_taken(0x100) = 1, br_count = 1, mispred_count = 1.
- Branch at 0x200, ex_pred_taken = 0, br_en = 0 -> no redirect or flush, br_count +1, mispred_count unchanged. Repeat 3x -> BHT entry saturates at 00.
- JAL at 0x300, ex_target = 0x400, with stall = 1 for 3 cycles -> no outputs during stall; first cycle stall = 0: redirect_pc = 0x400, flushes = 1; mispred_count +1 exactly once; BHT entry for 0x300 unchanged.
- Predicted-taken branch at 0x500, br_en = 0 -> redirect_pc = 0x504; four consecutive taken resolutions of one entry -> entry = 11, a fifth taken resolution leaves it 11.
- Write and read of the same index (if_pc = ex_pc = 0x600) in one cycle -> pred_taken shows the old MSB; next cycle shows the new MSB.
- rst low while in PEND -> outputs 0 immediately; after release, FSM = IDLE, counters = 0, all BHT entries = 01.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared types and helpers for the EX-stage branch resolution controller.
package branch_ctrl_pkg;

    // 2-bit saturating predictor counter; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } branch_ctrl_state_t;

    localparam bht_state_t BHT_RESET_VAL = WNT;

    // Saturating step of a predictor counter toward the resolved direction.
    function automatic bht_state_t bht_next(bht_state_t cur, logic taken);
        logic [1:0] v;
        v = cur;
        if (taken) begin
            if (v != 2'b11) v = v + 2'd1;
        end else begin
            if (v != 2'b00) v = v - 2'd1;
        end
        return bht_state_t'(v);
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Pipeline-facing signals of the branch controller: fetch prediction,
// EX-stage resolution inputs and the redirect/flush outputs.
interface branch_ctrl_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic [31:0] ex_target;
    logic        br_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;

    // Pipeline side: drives fetch PC and EX info, consumes prediction/redirect.
    modport master (
        output if_pc, stall, ex_valid, ex_is_branch, ex_is_jump, ex_pc,
               ex_pred_taken, ex_target, br_en,
        input  pred_taken, redirect_valid, redirect_pc, flush_if_id, flush_id_ex
    );

    // Controller side.
    modport slave (
        input  if_pc, stall, ex_valid, ex_is_branch, ex_is_jump, ex_pc,
               ex_pred_taken, ex_target, br_en,
        output pred_taken, redirect_valid, redirect_pc, flush_if_id, flush_id_ex
    );
endinterface

// File: rtl/branch_ctrl_bht.sv
// Branch history table: 2^IDX_W saturating 2-bit counters, one combinational
// read port for fetch and one write port for EX resolution. A write and a
// read of the same entry in one cycle return the old value (no bypass).
module branch_ctrl_bht
    import branch_ctrl_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_actual
);
    localparam int ENTRIES = 1 << IDX_W;

    bht_state_t tbl [ENTRIES];

    // Prediction is the MSB of the addressed counter.
    always_comb begin
        rd_taken = tbl[rd_idx][1];
    end

    // Counter array: reset to weakly not-taken, saturating update on write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] <= BHT_RESET_VAL;
        end else if (wr_en) begin
            tbl[wr_idx] <= bht_next(tbl[wr_idx], wr_actual);
        end
    end
endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: mispredict detection, PC redirect and flushes
// (held across stalls in PEND), BHT training and performance counters.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    branch_ctrl_if.slave     bus,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    branch_ctrl_state_t   state;
    logic [31:0]          pend_pc;
    logic                 pend_is_branch;
    logic                 pend_actual;
    logic [BHT_IDX_W-1:0] pend_idx;

    logic                 is_jmp, is_br, resolve, actual, mis;
    logic [31:0]          corr_pc;
    logic                 fire_now, fire_pend, retire;
    logic                 upd_is_br, upd_actual, upd_mis;
    logic [BHT_IDX_W-1:0] upd_idx;

    // Fetch PC bits outside the table index carry no prediction information.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.if_pc[1:0], bus.if_pc[31:BHT_IDX_W+2]};

    // Resolution of the EX instruction; a jump flag wins over a branch flag.
    always_comb begin
        is_jmp  = bus.ex_is_jump;
        is_br   = bus.ex_is_branch & ~bus.ex_is_jump;
        resolve = bus.ex_valid & (bus.ex_is_branch | bus.ex_is_jump);
        actual  = is_jmp | bus.br_en;
        mis     = is_jmp | (bus.br_en != bus.ex_pred_taken);
        corr_pc = actual ? bus.ex_target : bus.ex_pc + 32'd4;
    end

    // Redirect mux: immediate on an unstalled mispredict, or the held
    // redirect once the stall drops. Reset forces everything low at once.
    always_comb begin
        fire_now           = (state == IDLE) & resolve & mis & ~bus.stall;
        fire_pend          = (state == PEND) & ~bus.stall;
        bus.redirect_valid = rst & (fire_now | fire_pend);
        bus.flush_if_id    = bus.redirect_valid;
        bus.flush_id_ex    = bus.redirect_valid;
        bus.redirect_pc    = 32'd0;
        if (rst) begin
            if (fire_pend)     bus.redirect_pc = pend_pc;
            else if (fire_now) bus.redirect_pc = corr_pc;
        end
    end

    // Training/counting happens once, at the edge the instruction leaves EX;
    // in PEND the latched copy is used since ex_* may already have moved on.
    always_comb begin
        retire     = ~bus.stall & (((state == IDLE) & resolve) | (state == PEND));
        upd_is_br  = (state == PEND) ? pend_is_branch : is_br;
        upd_actual = (state == PEND) ? pend_actual    : actual;
        upd_mis    = (state == PEND) ? 1'b1           : mis;
        upd_idx    = (state == PEND) ? pend_idx       : bus.ex_pc[BHT_IDX_W+1:2];
    end

    branch_ctrl_bht #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (bus.if_pc[BHT_IDX_W+1:2]),
        .rd_taken  (bus.pred_taken),
        .wr_en     (retire & upd_is_br),
        .wr_idx    (upd_idx),
        .wr_actual (upd_actual)
    );

    // FSM: park a stalled mispredict in PEND until the pipeline moves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            pend_pc        <= '0;
            pend_is_branch <= 1'b0;
            pend_actual    <= 1'b0;
            pend_idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (resolve & mis & bus.stall) begin
                        state          <= PEND;
                        pend_pc        <= corr_pc;
                        pend_is_branch <= is_br;
                        pend_actual    <= actual;
                        pend_idx       <= bus.ex_pc[BHT_IDX_W+1:2];
                    end
                end
                PEND: begin
                    if (!bus.stall) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (retire) begin
            if (upd_is_br && br_count != '1)    br_count      <= br_count + CNT_W'(1);
            if (upd_mis && mispred_count != '1) mispred_count <= mispred_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: stimulus pushes expected redirect PCs into
// a queue, a negedge monitor pops and compares whenever a redirect appears.
module tb_branch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] br_count, mp_count;

    branch_ctrl_if bus ();

    branch_ctrl #(.BHT_IDX_W(6), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .br_count      (br_count),
        .mispred_count (mp_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          exp_br = 0;
    int          exp_mp = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every redirect must match the oldest expectation; flushes
    // without a redirect are errors.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.redirect_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL redirect_unexpected: got pc %h expected no redirect", bus.redirect_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("redirect_pc", bus.redirect_pc, mon_e);
                    chk("flush_if_id", 32'(bus.flush_if_id), 32'd1);
                    chk("flush_id_ex", 32'(bus.flush_id_ex), 32'd1);
                end
            end else if (bus.flush_if_id !== 1'b0 || bus.flush_id_ex !== 1'b0) begin
                total++; bad++;
                $display("FAIL flush_without_redirect: got %b%b expected 00", bus.flush_if_id, bus.flush_id_ex);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic set_ex(input logic br, input logic jmp, input logic [31:0] pc,
                          input logic pt, input logic [31:0] tgt, input logic en);
        bus.ex_valid      = 1'b1;
        bus.ex_is_branch  = br;
        bus.ex_is_jump    = jmp;
        bus.ex_pc         = pc;
        bus.ex_pred_taken = pt;
        bus.ex_target     = tgt;
        bus.br_en         = en;
    endtask

    task automatic clr_ex();
        bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_is_jump = 1'b0;
        bus.ex_pc = 32'd0; bus.ex_pred_taken = 1'b0; bus.ex_target = 32'd0;
        bus.br_en = 1'b0; bus.stall = 1'b0;
    endtask

    // One unstalled resolution cycle; a redirect, if expected, must be seen
    // in this same cycle.
    task automatic resolve(input logic br, input logic jmp, input logic [31:0] pc,
                           input logic pt, input logic [31:0] tgt, input logic en,
                           input logic redir, input logic [31:0] rpc);
        step();
        bus.stall = 1'b0;
        set_ex(br, jmp, pc, pt, tgt, en);
        if (redir) exp_q.push_back(rpc);
        mid();
        chk("redirect_same_cycle", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle();
        step(); clr_ex(); mid();
    endtask

    task automatic chk_cnt();
        chk("br_count", br_count, 32'(exp_br));
        chk("mispred_count", mp_count, 32'(exp_mp));
    endtask

    initial begin
        clr_ex();
        bus.if_pc = 32'h100;
        repeat (2) @(posedge clk);
        mid();
        chk("reset_pred", 32'(bus.pred_taken), 32'd0);
        chk("reset_redirect", 32'(bus.redirect_valid), 32'd0);
        chk_cnt();
        step(); rst = 1'b1;

        // Mispredicted taken branch, immediate redirect.
        resolve(1, 0, 32'h100, 0, 32'h80, 1, 1, 32'h80);
        chk("pred_before_update", 32'(bus.pred_taken), 32'd0);
        exp_br++; exp_mp++;
        idle();
        chk("pred_after_taken", 32'(bus.pred_taken), 32'd1);
        chk_cnt();

        // Three correct not-taken branches drive the entry to 00.
        repeat (3) begin
            resolve(1, 0, 32'h200, 0, 32'h999, 0, 0, 32'h0);
            exp_br++;
        end
        idle();
        chk_cnt();
        bus.if_pc = 32'h200; #1;
        chk("pred_nt", 32'(bus.pred_taken), 32'd0);
        // One taken from 00 only reaches 01: prediction stays not-taken.
        resolve(1, 0, 32'h200, 0, 32'h210, 1, 1, 32'h210);
        exp_br++; exp_mp++;
        idle();
        chk("bht_sat_low", 32'(bus.pred_taken), 32'd0);
        chk_cnt();

        // JAL held through a 3-cycle stall.
        bus.if_pc = 32'h300;
        step(); set_ex(0, 1, 32'h300, 0, 32'h400, 0); bus.stall = 1'b1; mid();
        repeat (2) begin step(); mid(); end
        chk_cnt();
        step(); bus.stall = 1'b0; exp_q.push_back(32'h400); mid();
        chk("pend_redirect_seen", 32'(exp_q.size()), 32'd0);
        exp_mp++;
        idle();
        chk_cnt();
        chk("jump_no_bht", 32'(bus.pred_taken), 32'd0);

        // Predicted taken but not taken: fall-through redirect.
        resolve(1, 0, 32'h500, 1, 32'h900, 0, 1, 32'h504);
        exp_br++; exp_mp++;

        // Five correct taken resolutions saturate at 11.
        bus.if_pc = 32'h700;
        repeat (5) begin
            resolve(1, 0, 32'h700, 1, 32'h780, 1, 0, 32'h0);
            exp_br++;
        end
        idle();
        chk("bht_sat_high", 32'(bus.pred_taken), 32'd1);
        resolve(1, 0, 32'h700, 1, 32'h780, 0, 1, 32'h704);
        exp_br++; exp_mp++;
        idle();
        chk("bht_11_to_10", 32'(bus.pred_taken), 32'd1);
        resolve(1, 0, 32'h700, 1, 32'h780, 0, 1, 32'h704);
        exp_br++; exp_mp++;
        idle();
        chk("bht_10_to_01", 32'(bus.pred_taken), 32'd0);
        chk_cnt();

        // Same-cycle write and read of one entry: no bypass.
        bus.if_pc = 32'h600;
        resolve(1, 0, 32'h600, 1, 32'h680, 1, 0, 32'h0);
        chk("no_bypass", 32'(bus.pred_taken), 32'd0);
        exp_br++;
        idle();
        chk("post_update", 32'(bus.pred_taken), 32'd1);

        // Fall-through address wraps at 2^32.
        resolve(1, 0, 32'hFFFF_FFFC, 1, 32'h10, 0, 1, 32'h0);
        exp_br++; exp_mp++;
        idle();
        chk_cnt();

        // Reset while a redirect is pending.
        bus.if_pc = 32'h100;
        step(); set_ex(1, 0, 32'h800, 0, 32'h880, 1); bus.stall = 1'b1; mid();
        step(); mid();
        step(); bus.stall = 1'b0; #1;
        chk("pend_release_valid", 32'(bus.redirect_valid), 32'd1);
        chk("pend_release_pc", bus.redirect_pc, 32'h880);
        rst = 1'b0; #1;
        chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
        chk("rst_flush", 32'({bus.flush_if_id, bus.flush_id_ex}), 32'd0);
        exp_br = 0; exp_mp = 0;
        chk_cnt();
        clr_ex();
        step(); rst = 1'b1;
        mid();
        chk("rst_bht_100", 32'(bus.pred_taken), 32'd0);
        bus.if_pc = 32'h600; #1;
        chk("rst_bht_600", 32'(bus.pred_taken), 32'd0);
        chk_cnt();
        // IDLE after reset: immediate redirect; entry back at 01 so one taken flips it.
        bus.if_pc = 32'h100;
        resolve(1, 0, 32'h100, 0, 32'h40, 1, 1, 32'h40);
        exp_br++; exp_mp++;
        idle();
        chk("rst_bht_wnt", 32'(bus.pred_taken), 32'd1);
        chk_cnt();

        repeat (2) idle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
